imem_req_adapter: RTL and testbench

Request/response front end for the instruction-memory SRAM wrapper. Converts the core fetch/load port (valid/ready request, valid/ready response) into the SRAM's active-low chip-select and active-low write-enable signalling. Absorbs the SRAM's fixed one-cycle read latency and the core's response back-pressure with a small in-order response FIFO. Sits directly upstream of the instruction SRAM top and feeds its csb/we/addr/wdata/wmask inputs.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_req_adapter_if.sv | 27 ++
 rtl/imem_rsp_fifo.sv | 65 ++++++
 rtl/imem_req_adapter.sv | 88 ++++++++
 tb/tb_imem_req_adapter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory request adapter:
// SRAM geometry, response FIFO entry, pending-stage record and address checking.
package imem_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_entry_t;

  typedef struct packed {
    logic valid;
    logic is_read;
    logic err;
  } pend_t;

  // A byte address faults when it is not word aligned or lies beyond the SRAM.
  function automatic logic addr_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);
  endfunction

endpackage

// File: rtl/imem_req_adapter_if.sv
// Core-side request/response handshake bundle. The core is the master and the
// adapter the slave.
interface imem_req_adapter_if;
  import imem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/imem_rsp_fifo.sv
// In-order circular response FIFO. The caller never pushes when full nor pops
// when empty; the adapter's credit rule and rsp_valid gating guarantee both.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  rsp_entry_t       push_data_i,
  input  logic             pop_i,
  output rsp_entry_t       head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  rsp_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop_i)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through count-qualified outputs.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/imem_req_adapter.sv
// Core fetch/load port to single-port SRAM adapter: checks addresses, drives the
// active-low SRAM strobes, absorbs the one-cycle read latency and response stalls.
module imem_req_adapter
  import imem_pkg::*;
#(
  parameter int RSP_DEPTH = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  imem_req_adapter_if.slave  core,
  output logic               sram_csb_o,
  output logic               sram_we_o,
  output logic [ADDR_W-1:0]  sram_addr_o,
  output logic [DATA_W-1:0]  sram_wdata_o,
  output logic [MASK_W-1:0]  sram_wmask_o,
  input  logic [DATA_W-1:0]  sram_rdata_i
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic             req_err;
  logic             fire;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   inflight;
  pend_t            pend_q, pend_d;
  rsp_entry_t       push_entry;
  rsp_entry_t       head_entry;

  // Every accepted request owns a FIFO slot from acceptance until its pop, so
  // credits count both queued entries and the one still in the pending stage.
  assign req_err        = addr_err(core.req_addr);
  assign inflight       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pend_q.valid};
  assign core.req_ready = !rst_i && (inflight < (CNT_W+1)'(RSP_DEPTH));
  assign fire           = core.req_valid && core.req_ready;

  assign sram_csb_o   = !(fire && !req_err);
  assign sram_we_o    = !(fire && core.req_we && !req_err);
  assign sram_addr_o  = core.req_addr[ADDR_W+1:2];
  assign sram_wdata_o = core.req_wdata;
  assign sram_wmask_o = core.req_wmask;

  always_comb begin
    pend_d = '0;
    if (fire) begin
      pend_d.valid   = 1'b1;
      pend_d.is_read = !core.req_we;
      pend_d.err     = req_err;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // Writes and faults still occupy a slot so responses stay strictly in order.
  always_comb begin
    push_entry       = '0;
    push_entry.rdata = (pend_q.is_read && !pend_q.err) ? sram_rdata_i : '0;
    push_entry.err   = pend_q.err;
  end

  assign push = pend_q.valid && !fifo_full;
  assign pop  = core.rsp_valid && core.rsp_ready;

  imem_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_entry),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign core.rsp_valid = !fifo_empty;
  assign core.rsp_rdata = fifo_empty ? '0 : head_entry.rdata;
  assign core.rsp_err   = fifo_empty ? 1'b0 : head_entry.err;

endmodule

// File: tb/tb_imem_req_adapter.sv
// Directed bench for imem_req_adapter: a vector table of single transactions
// plus hand sequences for streaming, back-pressure and mid-operation reset.
module tb_imem_req_adapter;

  logic        clk;
  logic        rst;
  logic        sramCsb;
  logic        sramWe;
  logic [12:0] sramAddr;
  logic [31:0] sramWdata;
  logic [3:0]  sramWmask;
  logic [31:0] sramRdata;
  logic [31:0] sramMem [8192];

  int assertCount = 0;
  int failCount   = 0;

  imem_req_adapter_if bus ();

  imem_req_adapter #(
    .RSP_DEPTH (3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core         (bus),
    .sram_csb_o   (sramCsb),
    .sram_we_o    (sramWe),
    .sram_addr_o  (sramAddr),
    .sram_wdata_o (sramWdata),
    .sram_wmask_o (sramWmask),
    .sram_rdata_i (sramRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: synchronous, read data valid one cycle after the access edge.
  always @(posedge clk) begin
    if (!sramCsb) begin
      if (!sramWe) begin
        for (int b = 0; b < 4; b++)
          if (sramWmask[b]) sramMem[sramAddr][b*8 +: 8] <= sramWdata[b*8 +: 8];
      end else begin
        sramRdata <= sramMem[sramAddr];
      end
    end
  end

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        expCsb;
    logic        expWe;
    logic [12:0] expAddr;
    logic        expErr;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic we,
                               input logic [31:0] wdata, input logic [3:0] wmask);
    bus.req_valid = valid;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
  endtask

  // No response may ever be pushed into a full FIFO.
  always @(negedge clk) begin
    if (!rst) begin
      assertCount++;
      if (dut.fifo_full && dut.pend_q.valid) begin
        failCount++;
        $display("[TB] FAIL fifo_overflow: push into full FIFO at %0t", $time);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int respCount;
    logic [31:0] streamExp [3];

    for (int i = 0; i < 8192; i++) sramMem[i] = 32'h0;
    sramMem[0]    = 32'h0BAD0000;
    sramMem[1]    = 32'h11111111;
    sramMem[2]    = 32'h22222222;
    sramMem[4]    = 32'hDEADBEEF;
    sramMem[8]    = 32'h11223344;
    sramMem[8191] = 32'hCAFEF00D;
    sramRdata     = 32'h0;

    vecs[0] = '{"rd_0x10",   32'h0000_0010, 1'b0, 32'h0,         4'hF, 1'b0, 1'b1, 13'd4,    1'b0, 32'hDEADBEEF};
    vecs[1] = '{"wr_0x20",   32'h0000_0020, 1'b1, 32'hA5A5A5A5,  4'h3, 1'b0, 1'b0, 13'd8,    1'b0, 32'h0};
    vecs[2] = '{"rd_0x20",   32'h0000_0020, 1'b0, 32'h0,         4'hF, 1'b0, 1'b1, 13'd8,    1'b0, 32'h1122A5A5};
    vecs[3] = '{"rd_mis",    32'h0000_0002, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1, 13'd0,    1'b1, 32'h0};
    vecs[4] = '{"rd_oor",    32'h0001_0000, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1, 13'd0,    1'b1, 32'h0};
    vecs[5] = '{"wr_mis",    32'h0000_0022, 1'b1, 32'hFFFFFFFF,  4'hF, 1'b1, 1'b1, 13'd8,    1'b1, 32'h0};
    vecs[6] = '{"rd_0x20b",  32'h0000_0020, 1'b0, 32'h0,         4'hF, 1'b0, 1'b1, 13'd8,    1'b0, 32'h1122A5A5};
    vecs[7] = '{"rd_top",    32'h0000_7FFC, 1'b0, 32'h0,         4'hF, 1'b0, 1'b1, 13'h1FFF, 1'b0, 32'hCAFEF00D};
    vecs[8] = '{"rd_oor_hi", 32'h8000_0000, 1'b0, 32'h0,         4'hF, 1'b1, 1'b1, 13'd0,    1'b1, 32'h0};

    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    applyStimulus(1'b1, 32'h10, 1'b1, 32'h0, 4'hF);
    #12;
    checkOutput("rst_req_ready", bus.req_ready, 1'b0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("rst_csb", sramCsb, 1'b1);
    checkOutput("rst_we", sramWe, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);

    // Table: one transaction at a time with the response consumed immediately.
    for (int v = 0; v < 9; v++) begin
      waitCycle();
      applyStimulus(1'b1, vecs[v].addr, vecs[v].we, vecs[v].wdata, vecs[v].wmask);
      @(negedge clk);
      checkOutput({vecs[v].name, "_ready"}, bus.req_ready, 1'b1);
      checkOutput({vecs[v].name, "_csb"}, sramCsb, vecs[v].expCsb);
      checkOutput({vecs[v].name, "_we"}, sramWe, vecs[v].expWe);
      checkOutput({vecs[v].name, "_addr"}, sramAddr, vecs[v].expAddr);
      checkOutput({vecs[v].name, "_wmask"}, sramWmask, vecs[v].wmask);
      waitCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      @(negedge clk);
      checkOutput({vecs[v].name, "_early_valid"}, bus.rsp_valid, 1'b0);
      waitCycle();
      @(negedge clk);
      checkOutput({vecs[v].name, "_rsp_valid"}, bus.rsp_valid, 1'b1);
      checkOutput({vecs[v].name, "_rdata"}, bus.rsp_rdata, vecs[v].expRdata);
      checkOutput({vecs[v].name, "_err"}, bus.rsp_err, vecs[v].expErr);
    end
    waitCycle();
    @(negedge clk);
    checkOutput("table_drained", bus.rsp_valid, 1'b0);

    // Back-to-back reads with the response side always ready.
    streamExp[0] = 32'h0BAD0000;
    streamExp[1] = 32'h11111111;
    streamExp[2] = 32'h22222222;
    for (int i = 0; i < 6; i++) begin
      waitCycle();
      if (i < 3) applyStimulus(1'b1, 32'(i * 4), 1'b0, 32'h0, 4'hF);
      else       applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      @(negedge clk);
      if (i < 3) checkOutput($sformatf("stream_ready_%0d", i), bus.req_ready, 1'b1);
      if (i >= 2 && i < 5) begin
        checkOutput($sformatf("stream_valid_%0d", i), bus.rsp_valid, 1'b1);
        checkOutput($sformatf("stream_rdata_%0d", i), bus.rsp_rdata, streamExp[i-2]);
      end
      if (i == 5) checkOutput("stream_done", bus.rsp_valid, 1'b0);
    end

    // Back-pressure: three accepts fill the credits; a single pop frees one.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      waitCycle();
      applyStimulus(1'b1, 32'(i * 4), 1'b0, 32'h0, 4'hF);
      @(negedge clk);
      checkOutput($sformatf("bp_accept_%0d", i), bus.req_ready, 1'b1);
    end
    for (int i = 3; i < 7; i++) begin
      waitCycle();
      applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 4'hF);
      @(negedge clk);
      checkOutput($sformatf("bp_stall_%0d", i), bus.req_ready, 1'b0);
      if (i >= 4) checkOutput($sformatf("bp_head_%0d", i), bus.rsp_rdata, 32'h0BAD0000);
    end
    waitCycle();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_pop_ready", bus.req_ready, 1'b0);
    checkOutput("bp_pop_rdata", bus.rsp_rdata, 32'h0BAD0000);
    waitCycle();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_reopen", bus.req_ready, 1'b1);
    checkOutput("bp_head_next", bus.rsp_rdata, 32'h11111111);
    waitCycle();
    applyStimulus(1'b1, 32'h7FFC, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    checkOutput("bp_fifth_blocked", bus.req_ready, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_drain0", bus.rsp_rdata, 32'h11111111);
    waitCycle();
    @(negedge clk);
    checkOutput("bp_drain1", bus.rsp_rdata, 32'h22222222);
    waitCycle();
    @(negedge clk);
    checkOutput("bp_drain2", bus.rsp_rdata, 32'hDEADBEEF);
    waitCycle();
    @(negedge clk);
    checkOutput("bp_drained", bus.rsp_valid, 1'b0);

    // Asynchronous reset with one pending and two queued responses.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      waitCycle();
      applyStimulus(1'b1, 32'(i * 4), 1'b0, 32'h0, 4'hF);
    end
    waitCycle();
    applyStimulus(1'b1, 32'h10, 1'b1, 32'h12345678, 4'hF);
    #1;
    checkOutput("pre_rst_valid", bus.rsp_valid, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("arst_req_ready", bus.req_ready, 1'b0);
    checkOutput("arst_rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("arst_rsp_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("arst_rsp_err", bus.rsp_err, 1'b0);
    checkOutput("arst_csb", sramCsb, 1'b1);
    checkOutput("arst_we", sramWe, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    bus.rsp_ready = 1'b1;
    waitCycle();
    applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    checkOutput("post_rst_ready", bus.req_ready, 1'b1);
    respCount = 0;
    for (int k = 1; k <= 6; k++) begin
      waitCycle();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
      @(negedge clk);
      if (bus.rsp_valid) respCount++;
      if (k == 2) begin
        checkOutput("post_rst_valid", bus.rsp_valid, 1'b1);
        checkOutput("post_rst_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      end
    end
    checkOutput("post_rst_count", 32'(respCount), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
